aplic_msi_gen: RTL and testbench

- Upstream neighbour of the IMSIC island's AXI-lite write path.
- Selects one pending, enabled interrupt source per transaction, using round-robin arbitration.
- Translates the selected source into an MSI: the address points at the target interrupt file page, and the data carries the EIID.
- Issues the MSI through the AXI-lite write master's start/busy handshake, so that `imsic_island_top` receives standard MSI writes.

---
 rtl/aplic_msi_gen.sv | 196 +++++++++++++++++++
 tb/tb_aplic_msi_gen.sv | 373 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aplic_msi_gen.sv
// aplic_msi_gen: round-robin selection of pending/enabled interrupt sources and
// conversion of the winner into an MSI write issued through a start/busy
// handshake to an AXI-lite write master feeding imsic_island_top.
//
// Ports:
//   i_clk, ni_rst            clock, synchronous active-low reset
//   i_domain_ie              global delivery enable
//   i_pending, i_enable      per-source pending level and enable (bit 0 unused)
//   i_target_hart/file/eiid  per-source MSI routing
//   o_claim                  one-hot 1-cycle claim pulse back to the gateway
//   o_wr_start               1-cycle start pulse to the write master
//   o_addr, o_data           MSI address/data, stable from start until done
//   i_wr_busy                write master has a transaction outstanding
//   o_busy                   FSM is not IDLE
//
// Optional build macro APLIC_MSI_GEN_STATS_EN adds saturating o_sent_cnt and
// o_drop_cnt counters.

module aplic_msi_gen #(
  parameter int unsigned NR_SRC                = 30,
  parameter int unsigned NR_IMSICS             = 1,
  parameter int unsigned NR_VS_FILES_PER_IMSIC = 0,
  parameter int unsigned AXI_ADDR_WIDTH        = 64,
  parameter int unsigned AXI_DATA_WIDTH        = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] IMSIC_BASE = AXI_ADDR_WIDTH'(64'h2400_0000),
  parameter int unsigned NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
  parameter int unsigned FILE_LEN              = $clog2(NR_INTP_FILES),
  parameter int unsigned HART_LEN              = (NR_IMSICS > 1) ? $clog2(NR_IMSICS) : 1
) (
  input  logic                               i_clk,
  input  logic                               ni_rst,
  input  logic                               i_domain_ie,
  input  logic [NR_SRC-1:0]                  i_pending,
  input  logic [NR_SRC-1:0]                  i_enable,
  input  logic [NR_SRC-1:0][HART_LEN-1:0]    i_target_hart,
  input  logic [NR_SRC-1:0][FILE_LEN-1:0]    i_target_file,
  input  logic [NR_SRC-1:0][10:0]            i_target_eiid,
  output logic [NR_SRC-1:0]                  o_claim,
  output logic                               o_wr_start,
  output logic [AXI_ADDR_WIDTH-1:0]          o_addr,
  output logic [AXI_DATA_WIDTH-1:0]          o_data,
  input  logic                               i_wr_busy,
  output logic                               o_busy
`ifdef APLIC_MSI_GEN_STATS_EN
  ,
  output logic [15:0]                        o_sent_cnt,
  output logic [15:0]                        o_drop_cnt
`endif
);

  localparam int unsigned IDX_W = $clog2(NR_SRC);
  localparam int unsigned TMO_W = 4;

  typedef enum logic [1:0] {IDLE, SEL, WAIT_HI, WAIT_LO} state_e;

  state_e             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   win_q;
  logic               valid_q;
  logic               claimed_q;
  logic [TMO_W-1:0]   tmo_q;

  logic [NR_SRC-1:0]         cand;
  logic                      any_cand;
  logic                      found_hi;
  logic [IDX_W-1:0]          win_hi;
  logic [IDX_W-1:0]          win_lo;
  logic [IDX_W-1:0]          win_c;
  logic [HART_LEN-1:0]       hart_c;
  logic [FILE_LEN-1:0]       file_c;
  logic [10:0]               eiid_c;
  logic                      valid_c;
  logic [AXI_ADDR_WIDTH-1:0] file_idx_c;
  logic [AXI_ADDR_WIDTH-1:0] addr_c;
  logic [AXI_DATA_WIDTH-1:0] data_c;

  // Round-robin pick: lowest candidate above the pointer, else lowest overall.
  always_comb begin
    cand     = i_pending & i_enable & {NR_SRC{i_domain_ie}};
    cand[0]  = 1'b0;
    any_cand = |cand;
    found_hi = 1'b0;
    win_hi   = '0;
    win_lo   = '0;
    for (int k = NR_SRC - 1; k >= 1; k--) begin
      if (cand[k]) begin
        win_lo = IDX_W'(k);
        if (k > int'(rr_ptr)) begin
          win_hi   = IDX_W'(k);
          found_hi = 1'b1;
        end
      end
    end
    win_c = found_hi ? win_hi : win_lo;
  end

  // MSI target decode for the current winner; one 4 KiB page per file.
  always_comb begin
    hart_c     = i_target_hart[win_c];
    file_c     = i_target_file[win_c];
    eiid_c     = i_target_eiid[win_c];
    valid_c    = (eiid_c != 11'd0) &&
                 (32'(hart_c) < NR_IMSICS) &&
                 (32'(file_c) < NR_INTP_FILES);
    file_idx_c = AXI_ADDR_WIDTH'(hart_c) * AXI_ADDR_WIDTH'(NR_INTP_FILES) +
                 AXI_ADDR_WIDTH'(file_c);
    addr_c     = IMSIC_BASE + (file_idx_c << 12);
    data_c     = AXI_DATA_WIDTH'(eiid_c);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_q      <= '0;
      valid_q    <= 1'b0;
      claimed_q  <= 1'b0;
      tmo_q      <= '0;
      o_claim    <= '0;
      o_wr_start <= 1'b0;
      o_addr     <= '0;
      o_data     <= '0;
      o_busy     <= 1'b0;
    end else begin
      o_claim    <= '0;
      o_wr_start <= 1'b0;
      case (state)
        IDLE: begin
          if (any_cand) begin
            win_q     <= win_c;
            valid_q   <= valid_c;
            o_addr    <= addr_c;
            o_data    <= data_c;
            claimed_q <= 1'b0;
            o_busy    <= 1'b1;
            state     <= SEL;
          end
        end
        SEL: begin
          // Claim only on the first SEL cycle even if the master stalls us.
          if (!claimed_q) begin
            o_claim <= NR_SRC'(1) << win_q;
            rr_ptr  <= win_q;
          end
          claimed_q <= 1'b1;
          if (!valid_q) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else if (!i_wr_busy) begin
            o_wr_start <= 1'b1;
            tmo_q      <= '0;
            state      <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          // Busy never seen within 16 cycles: assume the write completed.
          if (i_wr_busy) begin
            state <= WAIT_LO;
          end else if (tmo_q == {TMO_W{1'b1}}) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        WAIT_LO: begin
          if (!i_wr_busy) begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef APLIC_MSI_GEN_STATS_EN
  // Saturating sent/dropped counters, updated alongside start and drop claims.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      o_sent_cnt <= '0;
      o_drop_cnt <= '0;
    end else if (state == SEL) begin
      if (valid_q && !i_wr_busy && (o_sent_cnt != 16'hFFFF))
        o_sent_cnt <= o_sent_cnt + 16'd1;
      if (!valid_q && (o_drop_cnt != 16'hFFFF))
        o_drop_cnt <= o_drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_aplic_msi_gen.sv
// Self-checking bench for aplic_msi_gen: scoreboard of expected claims and MSI
// writes, a simple gateway (clears pending on claim) and write-master model.

module tb_aplic_msi_gen;

  localparam int unsigned NR_SRC   = 30;
  localparam int unsigned HART_LEN = 1;
  localparam int unsigned FILE_LEN = 1;
  localparam logic [63:0] BASE     = 64'h2400_0000;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                            rst_n;
  logic                            domain_ie;
  logic [NR_SRC-1:0]               pending;
  logic [NR_SRC-1:0]               enable;
  logic [NR_SRC-1:0][HART_LEN-1:0] hart;
  logic [NR_SRC-1:0][FILE_LEN-1:0] file;
  logic [NR_SRC-1:0][10:0]         eiid;
  logic [NR_SRC-1:0]               o_claim;
  logic                            o_wr_start;
  logic [63:0]                     o_addr;
  logic [63:0]                     o_data;
  logic                            wr_busy;
  logic                            o_busy;
`ifdef APLIC_MSI_GEN_STATS_EN
  logic [15:0]                     sent_cnt;
  logic [15:0]                     drop_cnt;
`endif

  aplic_msi_gen dut (
    .i_clk         (clk),
    .ni_rst        (rst_n),
    .i_domain_ie   (domain_ie),
    .i_pending     (pending),
    .i_enable      (enable),
    .i_target_hart (hart),
    .i_target_file (file),
    .i_target_eiid (eiid),
    .o_claim       (o_claim),
    .o_wr_start    (o_wr_start),
    .o_addr        (o_addr),
    .o_data        (o_data),
    .i_wr_busy     (wr_busy),
    .o_busy        (o_busy)
`ifdef APLIC_MSI_GEN_STATS_EN
    ,
    .o_sent_cnt    (sent_cnt),
    .o_drop_cnt    (drop_cnt)
`endif
  );

  logic [NR_SRC-1:0] exp_claim_q[$];
  wr_t               exp_wr_q[$];
  int  n_pass     = 0;
  int  n_total    = 0;
  int  n_claims   = 0;
  int  n_starts   = 0;
  int  busy_cnt   = 0;
  int  busy_len   = 3;
  bit  hold_busy  = 1'b0;
  bit  auto_clear = 1'b1;

  function automatic logic [NR_SRC-1:0] onehot(input int k);
    return NR_SRC'(1) << k;
  endfunction

  // Advance one cycle, score DUT events at the falling edge, run the models.
  task automatic cycle();
    logic [NR_SRC-1:0] ec;
    wr_t               ew;
    @(negedge clk);
    if (o_claim !== '0) begin
      n_claims++;
      n_total++;
      if (exp_claim_q.size() == 0) begin
        $display("FAIL claim_unexpected: got %h, required no claim", o_claim);
      end else begin
        ec = exp_claim_q.pop_front();
        if (o_claim !== ec) $display("FAIL claim_order: got %h, required %h", o_claim, ec);
        else n_pass++;
      end
      if (auto_clear) pending = pending & ~o_claim;
    end
    if (o_wr_start === 1'b1) begin
      n_starts++;
      n_total++;
      if (exp_wr_q.size() == 0) begin
        $display("FAIL write_unexpected: got addr %h data %h, required no write", o_addr, o_data);
      end else begin
        ew = exp_wr_q.pop_front();
        if (o_addr !== ew.addr || o_data !== ew.data)
          $display("FAIL write_payload: got addr %h data %h, required addr %h data %h",
                   o_addr, o_data, ew.addr, ew.data);
        else n_pass++;
      end
      busy_cnt = busy_len;
    end
    wr_busy = hold_busy || (busy_cnt != 0);
    if (busy_cnt != 0) busy_cnt--;
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      cycle();
      if (!o_busy && !wr_busy && exp_claim_q.size() == 0 && exp_wr_q.size() == 0) break;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) cycle();
    n_total++;
    if (o_claim !== '0 || o_wr_start !== 1'b0 || o_busy !== 1'b0)
      $display("FAIL reset_ctrl: got claim %h start %b busy %b, required 0 0 0",
               o_claim, o_wr_start, o_busy);
    else n_pass++;
    n_total++;
    if (o_addr !== 64'd0 || o_data !== 64'd0)
      $display("FAIL reset_bus: got addr %h data %h, required 0 0", o_addr, o_data);
    else n_pass++;
`ifdef APLIC_MSI_GEN_STATS_EN
    n_total++;
    if (sent_cnt !== 16'd0 || drop_cnt !== 16'd0)
      $display("FAIL reset_stats: got %0d %0d, required 0 0", sent_cnt, drop_cnt);
    else n_pass++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    int c0;
    c0 = n_claims;
    auto_clear = 1'b0;
    exp_claim_q.push_back(onehot(3));
    exp_claim_q.push_back(onehot(9));
    exp_claim_q.push_back(onehot(20));
    exp_claim_q.push_back(onehot(3));
    exp_wr_q.push_back('{addr: BASE, data: 64'd3});
    exp_wr_q.push_back('{addr: BASE, data: 64'd9});
    exp_wr_q.push_back('{addr: BASE, data: 64'd20});
    exp_wr_q.push_back('{addr: BASE, data: 64'd3});
    pending = onehot(3) | onehot(9) | onehot(20);
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (n_claims == c0 + 4) break;
    end
    pending = '0;
    auto_clear = 1'b1;
    wait_idle(60);
    n_total++;
    if (o_busy !== 1'b0 || exp_claim_q.size() != 0 || exp_wr_q.size() != 0)
      $display("FAIL rr_drain: got busy %b claims_left %0d writes_left %0d, required 0 0 0",
               o_busy, exp_claim_q.size(), exp_wr_q.size());
    else n_pass++;
  endtask

  task automatic test_basic();
    hart[5] = 1'b0;
    file[5] = 1'b1;
    eiid[5] = 11'd7;
    exp_claim_q.push_back(onehot(5));
    exp_wr_q.push_back('{addr: 64'h2400_1000, data: 64'd7});
    pending[5] = 1'b1;
    cycle();
    n_total++;
    if (o_claim !== '0 || o_busy !== 1'b1)
      $display("FAIL basic_lat1: got claim %h busy %b, required 0 1", o_claim, o_busy);
    else n_pass++;
    cycle();
    n_total++;
    if (o_wr_start !== 1'b1)
      $display("FAIL basic_lat2: got start %b, required 1", o_wr_start);
    else n_pass++;
    wait_idle(40);
    n_total++;
    if (o_busy !== 1'b0 || exp_claim_q.size() != 0 || exp_wr_q.size() != 0)
      $display("FAIL basic_drain: got busy %b claims_left %0d writes_left %0d, required 0 0 0",
               o_busy, exp_claim_q.size(), exp_wr_q.size());
    else n_pass++;
  endtask

  task automatic test_invalid();
    eiid[4] = 11'd0;
    exp_claim_q.push_back(onehot(4));
    pending[4] = 1'b1;
    cycle();
    cycle();
    n_total++;
    if (o_wr_start !== 1'b0)
      $display("FAIL inv_eiid_start: got %b, required 0", o_wr_start);
    else n_pass++;
    cycle();
    n_total++;
    if (o_busy !== 1'b0)
      $display("FAIL inv_eiid_idle: got busy %b, required 0", o_busy);
    else n_pass++;
`ifdef APLIC_MSI_GEN_STATS_EN
    n_total++;
    if (drop_cnt !== 16'd1)
      $display("FAIL inv_drop_cnt: got %0d, required 1", drop_cnt);
    else n_pass++;
`endif
    // Hart index beyond the single IMSIC is dropped as well.
    hart[6] = 1'b1;
    exp_claim_q.push_back(onehot(6));
    pending[6] = 1'b1;
    cycle();
    cycle();
    n_total++;
    if (o_wr_start !== 1'b0)
      $display("FAIL inv_hart_start: got %b, required 0", o_wr_start);
    else n_pass++;
    wait_idle(20);
    n_total++;
    if (o_busy !== 1'b0 || exp_claim_q.size() != 0)
      $display("FAIL inv_drain: got busy %b claims_left %0d, required 0 0",
               o_busy, exp_claim_q.size());
    else n_pass++;
`ifdef APLIC_MSI_GEN_STATS_EN
    n_total++;
    if (drop_cnt !== 16'd2 || sent_cnt !== 16'd5)
      $display("FAIL inv_stats: got drop %0d sent %0d, required 2 5", drop_cnt, sent_cnt);
    else n_pass++;
`endif
    eiid[4] = 11'd4;
    hart[6] = 1'b0;
  endtask

  task automatic test_busy_stall();
    int  c0;
    bit  bad;
    c0 = n_claims;
    bad = 1'b0;
    hold_busy = 1'b1;
    wr_busy   = 1'b1;
    file[7] = 1'b1;
    eiid[7] = 11'h7FF;
    exp_claim_q.push_back(onehot(7));
    exp_wr_q.push_back('{addr: 64'h2400_1000, data: 64'h7FF});
    pending[7] = 1'b1;
    cycle();
    cycle();
    n_total++;
    if (o_wr_start !== 1'b0 || n_claims != c0 + 1)
      $display("FAIL stall_first: got start %b claims %0d, required 0 1", o_wr_start, n_claims - c0);
    else n_pass++;
    repeat (6) begin
      cycle();
      if (o_claim !== '0 || o_wr_start !== 1'b0 || o_addr !== 64'h2400_1000 || o_busy !== 1'b1)
        bad = 1'b1;
    end
    n_total++;
    if (bad) $display("FAIL stall_hold: got unstable outputs during stall, required held addr and no pulses");
    else n_pass++;
    hold_busy = 1'b0;
    wait_idle(40);
    n_total++;
    if (o_busy !== 1'b0 || exp_wr_q.size() != 0 || n_claims != c0 + 1)
      $display("FAIL stall_drain: got busy %b writes_left %0d claims %0d, required 0 0 1",
               o_busy, exp_wr_q.size(), n_claims - c0);
    else n_pass++;
    file[7] = 1'b0;
    eiid[7] = 11'd7;
  endtask

  task automatic test_gating();
    bit act;
    act = 1'b0;
    pending = onehot(0);
    repeat (10) begin
      cycle();
      if (o_busy !== 1'b0 || o_wr_start !== 1'b0 || o_claim !== '0) act = 1'b1;
    end
    n_total++;
    if (act) $display("FAIL gate_idx0: got activity, required none");
    else n_pass++;
    pending   = '0;
    domain_ie = 1'b0;
    pending   = 30'h0000_003E;
    act       = 1'b0;
    repeat (10) begin
      cycle();
      if (o_busy !== 1'b0 || o_wr_start !== 1'b0 || o_claim !== '0) act = 1'b1;
    end
    n_total++;
    if (act) $display("FAIL gate_domain_ie: got activity, required none");
    else n_pass++;
    pending   = '0;
    domain_ie = 1'b1;
  endtask

  task automatic test_reset_mid();
    int s0;
    s0 = n_starts;
    busy_len = 10;
    exp_claim_q.push_back(onehot(10));
    exp_wr_q.push_back('{addr: BASE, data: 64'd10});
    pending[10] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (n_starts == s0 + 1) break;
    end
    cycle();
    cycle();
    n_total++;
    if (o_busy !== 1'b1 || wr_busy !== 1'b1)
      $display("FAIL rst_mid_busy: got busy %b wr_busy %b, required 1 1", o_busy, wr_busy);
    else n_pass++;
    rst_n = 1'b0;
    cycle();
    n_total++;
    if (o_claim !== '0 || o_wr_start !== 1'b0 || o_busy !== 1'b0 ||
        o_addr !== 64'd0 || o_data !== 64'd0)
      $display("FAIL rst_mid_clear: got claim %h start %b busy %b addr %h data %h, required all 0",
               o_claim, o_wr_start, o_busy, o_addr, o_data);
    else n_pass++;
    rst_n    = 1'b1;
    busy_cnt = 0;
    busy_len = 3;
    wr_busy  = 1'b0;
    file[2] = 1'b1;
    eiid[2] = 11'd2;
    exp_claim_q.push_back(onehot(2));
    exp_wr_q.push_back('{addr: 64'h2400_1000, data: 64'd2});
    pending[2] = 1'b1;
    cycle();
    cycle();
    n_total++;
    if (o_wr_start !== 1'b1)
      $display("FAIL resume_lat: got start %b, required 1", o_wr_start);
    else n_pass++;
    wait_idle(40);
    n_total++;
    if (o_busy !== 1'b0 || exp_claim_q.size() != 0 || exp_wr_q.size() != 0)
      $display("FAIL resume_drain: got busy %b claims_left %0d writes_left %0d, required 0 0 0",
               o_busy, exp_claim_q.size(), exp_wr_q.size());
    else n_pass++;
`ifdef APLIC_MSI_GEN_STATS_EN
    n_total++;
    if (sent_cnt !== 16'd1 || drop_cnt !== 16'd0)
      $display("FAIL resume_stats: got sent %0d drop %0d, required 1 0", sent_cnt, drop_cnt);
    else n_pass++;
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    domain_ie = 1'b1;
    pending   = '0;
    enable    = '1;
    hart      = '0;
    file      = '0;
    wr_busy   = 1'b0;
    for (int k = 0; k < int'(NR_SRC); k++) eiid[k] = 11'(k);
    test_reset();
    test_round_robin();
    test_basic();
    test_invalid();
    test_busy_stall();
    test_gating();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
